div_seq: RTL and testbench

- Parametrised multi-cycle integer divider for the MIPS core's DIV/DIVU path, and the next generation of the existing unsigned divider.
- Adds signed mode, a start/busy/done handshake and normalisation done internally (caller passes raw operands).
- Also adds a divide-by-zero flag and fixed, documented latency.
- Sits beside the multiplier; the HI/LO writeback logic captures the results when done is high.

---
 rtl/div_pkg.sv | 33 +++
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 151 +++++++++++++++
 tb/tb_div_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider (and the multiplier that
// sits beside it on the HI/LO path).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_W_DEFAULT = 32;
    localparam int DIV_MAX_W     = 64;

    // Magnitude of a width-bit operand carried in a DIV_MAX_W container.
    // The most negative value maps to itself, which reads correctly as unsigned.
    function automatic logic [DIV_MAX_W-1:0] abs_w(
        input logic [DIV_MAX_W-1:0] value,
        input int unsigned          width,
        input logic                 signed_mode
    );
        logic [DIV_MAX_W-1:0] mask;
        logic                 sign;
        mask = (width >= DIV_MAX_W) ? '1
                                    : ((DIV_MAX_W'(1) << width) - DIV_MAX_W'(1));
        sign = |(value & (DIV_MAX_W'(1) << (width - 1)));
        if (signed_mode && sign) begin
            return (~value + DIV_MAX_W'(1)) & mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    localparam int RW = WIDTH + 1;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    assign shifted     = {rem, dvd_msb};
    assign divisor_ext = {2'b00, divisor};
    assign q_bit       = (shifted >= divisor_ext);
    assign rem_next    = q_bit ? RW'(shifted - divisor_ext) : RW'(shifted);

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned integer divider: magnitudes are divided with a
// restoring loop, one quotient bit per clock, then signs are reapplied.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             divrst_n,
    input  logic             divstart,
    input  logic             divsigned,
    input  logic [WIDTH-1:0] diva,
    input  logic [WIDTH-1:0] divb,
    output logic             divbusy,
    output logic             divdone,
    output logic [WIDTH-1:0] divq,
    output logic [WIDTH-1:0] divr,
    output logic             divzero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;
    logic [WIDTH-1:0] bmag_reg, bmag_next;
    logic             qneg_reg, qneg_next;
    logic             rneg_reg, rneg_next;
    logic [WIDTH-1:0] divq_reg, divq_next;
    logic [WIDTH-1:0] divr_reg, divr_next;
    logic             zero_reg, zero_next;

    logic [DIV_MAX_W-1:0] a_ext, b_ext;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       step_rem;
    logic                 step_bit;
    logic                 accept;

    // Zero-extend operands into the package helper's fixed-width container.
    genvar gi;
    for (gi = 0; gi < DIV_MAX_W; gi++) begin : g_ext
        if (gi < WIDTH) begin : g_bit
            assign a_ext[gi] = diva[gi];
            assign b_ext[gi] = divb[gi];
        end else begin : g_pad
            assign a_ext[gi] = 1'b0;
            assign b_ext[gi] = 1'b0;
        end
    end

    assign a_mag = WIDTH'(abs_w(a_ext, WIDTH, divsigned));
    assign b_mag = WIDTH'(abs_w(b_ext, WIDTH, divsigned));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_reg),
        .dvd_msb (dvd_reg[WIDTH-1]),
        .divisor (bmag_reg),
        .rem_next(step_rem),
        .q_bit   (step_bit)
    );

    assign accept = divstart && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rem_next   = rem_reg;
        dvd_next   = dvd_reg;
        bmag_next  = bmag_reg;
        qneg_next  = qneg_reg;
        rneg_next  = rneg_reg;
        divq_next  = divq_reg;
        divr_next  = divr_reg;
        zero_next  = zero_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (accept) begin
                    qneg_next = divsigned & (diva[WIDTH-1] ^ divb[WIDTH-1]);
                    rneg_next = divsigned & diva[WIDTH-1];
                    dvd_next  = a_mag;
                    bmag_next = b_mag;
                    rem_next  = '0;
                    cnt_next  = CNT_W'(WIDTH);
                    zero_next = 1'b0;
                    if (divb == '0) begin
                        // Divide by zero skips the loop and reports the raw dividend.
                        state_next = DONE;
                        zero_next  = 1'b1;
                        divq_next  = '1;
                        divr_next  = diva;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                rem_next = step_rem;
                dvd_next = {dvd_reg[WIDTH-2:0], step_bit};
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                divq_next  = qneg_reg ? -dvd_reg : dvd_reg;
                divr_next  = rneg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge divrst_n) begin
        if (!divrst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            bmag_reg  <= '0;
            qneg_reg  <= 1'b0;
            rneg_reg  <= 1'b0;
            divq_reg  <= '0;
            divr_reg  <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rem_reg   <= rem_next;
            dvd_reg   <= dvd_next;
            bmag_reg  <= bmag_next;
            qneg_reg  <= qneg_next;
            rneg_reg  <= rneg_next;
            divq_reg  <= divq_next;
            divr_reg  <= divr_next;
            zero_reg  <= zero_next;
        end
    end

    assign divbusy = (state_reg == RUN) || (state_reg == FIX);
    assign divdone = (state_reg == DONE);
    assign divq    = divq_reg;
    assign divr    = divr_reg;
    assign divzero = zero_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a 32-bit and an 8-bit instance driven from
// a vector table, hand-written handshake/reset sequences and random operands.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0;
    logic        start8 = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic        busy32, done32, zero32;
    logic [31:0] q32, r32;
    logic        busy8, done8, zero8;
    logic [7:0]  q8, r8;

    int n_vec = 0;
    int n_mis = 0;
    int n_cmp = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        bit          z;
        int          w;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        bit          z;
    } vec_t;

    always #5 clk = ~clk;

    div_seq dut32 (
        .clk      (clk),
        .divrst_n (rst_n),
        .divstart (start32),
        .divsigned(sgn),
        .diva     (a_in),
        .divb     (b_in),
        .divbusy  (busy32),
        .divdone  (done32),
        .divq     (q32),
        .divr     (r32),
        .divzero  (zero32)
    );

    div_seq #(
        .WIDTH(8)
    ) dut8 (
        .clk      (clk),
        .divrst_n (rst_n),
        .divstart (start8),
        .divsigned(sgn),
        .diva     (a_in[7:0]),
        .divb     (b_in[7:0]),
        .divbusy  (busy8),
        .divdone  (done8),
        .divq     (q8),
        .divr     (r8),
        .divzero  (zero8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic get_out(input int w, output logic bsy, output logic dn, output logic zr,
                           output logic [31:0] q, output logic [31:0] r);
        if (w == 8) begin
            bsy = busy8; dn = done8; zr = zero8;
            q = {24'b0, q8}; r = {24'b0, r8};
        end else begin
            bsy = busy32; dn = done32; zr = zero32;
            q = q32; r = r32;
        end
    endtask

    // Reference: native 64-bit arithmetic on sign/zero-extended operands.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input int w, input bit s,
                           output logic [31:0] q, output logic [31:0] r, output bit z);
        longint unsigned mask, ua, ub;
        longint sa, sbv;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        if (ub == 0) begin
            q = 32'(mask); r = 32'(ua); z = 1'b1;
        end else if (s) begin
            sa  = $signed(ua << (64 - w)) >>> (64 - w);
            sbv = $signed(ub << (64 - w)) >>> (64 - w);
            q = 32'(longint'(sa / sbv) & mask);
            r = 32'(longint'(sa % sbv) & mask);
            z = 1'b0;
        end else begin
            q = 32'(ua / ub); r = 32'(ua % ub); z = 1'b0;
        end
    endtask

    // glitch_at >= 0 pulses a bogus start that many edges after acceptance.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [31:0] eq, input logic [31:0] er, input bit ez,
                         input string nm, input int glitch_at);
        exp_t e;
        int n, bc, lat;
        logic bsy, dn, zr;
        logic [31:0] q, r;
        e.q = eq; e.r = er; e.z = ez; e.w = w;
        sb.push_back(e);
        @(negedge clk);
        a_in = a; b_in = b; sgn = s;
        if (w == 8) start8 = 1'b1; else start32 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        a_in = $urandom; b_in = $urandom; sgn = 1'($urandom);
        n = 0; bc = 0;
        get_out(w, bsy, dn, zr, q, r);
        while (!dn && n <= w + 4) begin
            if (bsy) bc++;
            if (n == glitch_at) begin
                a_in = 32'd5; b_in = 32'd0; sgn = 1'b1;
                if (w == 8) start8 = 1'b1; else start32 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0; start32 = 1'b0;
            n++;
            get_out(w, bsy, dn, zr, q, r);
        end
        if (bsy) bc++;
        n_vec++;
        e = sb.pop_front();
        lat = e.z ? 0 : e.w + 1;
        $display("op %-12s w=%0d a=%h b=%h s=%0d -> q=%h r=%h z=%0d lat=%0d",
                 nm, w, a, b, s, q, r, zr, n);
        check({nm, " latency"}, 32'(n), 32'(lat));
        check({nm, " busy_cycles"}, 32'(bc), 32'(lat));
        check({nm, " done"}, {31'b0, dn}, 32'd1);
        check({nm, " q"}, q, e.q);
        check({nm, " r"}, r, e.r);
        check({nm, " zero"}, {31'b0, zr}, {31'b0, e.z});
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " q32"}, q32, 32'd0);
        check({nm, " r32"}, r32, 32'd0);
        check({nm, " busy32"}, {31'b0, busy32}, 32'd0);
        check({nm, " done32"}, {31'b0, done32}, 32'd0);
        check({nm, " zero32"}, {31'b0, zero32}, 32'd0);
        check({nm, " q8"}, {24'b0, q8}, 32'd0);
        check({nm, " r8"}, {24'b0, r8}, 32'd0);
        check({nm, " done8"}, {31'b0, done8}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[$];
        logic [31:0] eq, er, a, b;
        bit ez;

        vt.push_back('{"u100/7",   32, 32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
        vt.push_back('{"s-7/2",    32, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
        vt.push_back('{"s7/-2",    32, 32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0});
        vt.push_back('{"u5/0",     32, 32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1});
        vt.push_back('{"s5/0",     32, 32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1});
        vt.push_back('{"s-7/0",    32, 32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1});
        vt.push_back('{"s_ovf",    32, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0});
        vt.push_back('{"u_ovf",    32, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0});
        vt.push_back('{"s-100/-7", 32, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0});
        vt.push_back('{"umax/1",   32, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0});
        vt.push_back('{"u3/5",     32, 32'd3,          32'd5,          1'b0, 32'd0,          32'd3,          1'b0});
        vt.push_back('{"w8 200/3", 8,  32'd200,        32'd3,          1'b0, 32'd66,         32'd2,          1'b0});
        vt.push_back('{"w8 s-128/-1", 8, 32'h80,       32'hFF,         1'b1, 32'h80,         32'd0,          1'b0});

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            do_op(vt[i].w, vt[i].a, vt[i].b, vt[i].s, vt[i].q, vt[i].r, vt[i].z, vt[i].name, -1);
        end

        // Results stay put while idling in DONE.
        do_op(32, 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 1'b0, "hold", -1);
        repeat (3) @(posedge clk);
        #1;
        check("hold q stable", q32, 32'd111);
        check("hold r stable", r32, 32'd1);
        check("hold done stable", {31'b0, done32}, 32'd1);

        // A start pulse mid-operation must not disturb the running divide.
        do_op(32, 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 1'b0, "midstart", 10);

        // Asynchronous reset mid-operation clears everything at once.
        @(negedge clk);
        a_in = 32'd100; b_in = 32'd7; sgn = 1'b0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "after_rst", -1);

        for (int mode = 0; mode < 2; mode++) begin
            for (int k = 0; k < 2; k++) begin
                int w, cnt;
                w   = (k == 0) ? 32 : 8;
                cnt = (k == 0) ? 120 : 500;
                for (int i = 0; i < cnt; i++) begin
                    a = $urandom;
                    b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
                    if (mode == 1 && $urandom_range(0, 1) == 1) b = -b;
                    if (w == 8) begin
                        a = a & 32'hFF;
                        b = b & 32'hFF;
                    end
                    ref_div(a, b, w, bit'(mode), eq, er, ez);
                    do_op(w, a, b, bit'(mode), eq, er, ez, $sformatf("rnd%0d", i), -1);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
